// File: rtl/accel_fmt_pkg.sv
// accel_fmt_pkg: shared constants, FSM state type and the hex helper for the
// accelerometer ASCII line formatter.
package accel_fmt_pkg;

  localparam int SAMPLE_W = 48;

  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_Y     = 8'h59;
  localparam logic [7:0] CH_Z     = 8'h5A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [2:0] {IDLE, EMIT, ACK, DRAIN, GAP} fmt_state_e;

  // Uppercase ASCII hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/accel_sample_buf.sv
// accel_sample_buf: two-entry sample buffer. PEND takes new samples over the
// valid/ready handshake; a pop moves PEND into ACTIVE, which the formatter
// reads for the whole line.
module accel_sample_buf
  import accel_fmt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_pop,
  output logic                o_pend_full,
  output logic [SAMPLE_W-1:0] o_active
);

  logic                r_pend_full;
  logic [SAMPLE_W-1:0] r_pend;
  logic [SAMPLE_W-1:0] r_active;
  logic                w_accept;

  assign o_ready     = !r_pend_full;
  assign w_accept    = i_valid && o_ready;
  assign o_pend_full = r_pend_full;
  assign o_active    = r_active;

  // PEND capture and PEND->ACTIVE move; an accept alongside a pop keeps PEND full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full <= 1'b0;
      r_pend      <= '0;
      r_active    <= '0;
    end else begin
      if (i_pop)    r_active <= r_pend;
      if (w_accept) r_pend   <= i_data;
      r_pend_full <= w_accept || (r_pend_full && !i_pop);
    end
  end

endmodule

// File: rtl/accel_frame_fmt.sv
// accel_frame_fmt: turns 6-byte accelerometer samples into the ASCII line
// "X=HHHH,Y=HHHH,Z=HHHH" + terminator and feeds it byte by byte to uart_tx.
// Optional: define ACCEL_FRAME_CSUM_EN to append "*HH" (XOR of chars 0..19)
// before the terminator.
module accel_frame_fmt
  import accel_fmt_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int CRLF       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  output logic                frame_active,
  output logic [15:0]         frames_sent
);

`ifdef ACCEL_FRAME_CSUM_EN
  localparam int TERM_K = 23;
`else
  localparam int TERM_K = 20;
`endif
  localparam logic [5:0]  LAST_K   = 6'(TERM_K + ((CRLF != 0) ? 1 : 0));
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  fmt_state_e          r_state;
  logic [5:0]          r_k;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic [15:0]         r_frames;
  logic [15:0]         r_gap_cnt;
`ifdef ACCEL_FRAME_CSUM_EN
  logic [7:0]          r_csum;
`endif
  logic                w_pop;
  logic                w_pend_full;
  logic [SAMPLE_W-1:0] w_act;
  logic [7:0]          w_char;

  // ACTIVE is only reloaded on leaving IDLE, so it is stable for a whole line.
  assign w_pop = (r_state == IDLE) && w_pend_full;

  accel_sample_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (s_valid),
    .o_ready     (s_ready),
    .i_data      (s_data),
    .i_pop       (w_pop),
    .o_pend_full (w_pend_full),
    .o_active    (w_act)
  );

  // Character for index k; anything past the payload is the terminator.
  always_comb begin
    w_char = CH_LF;
    case (r_k)
      6'd0:                w_char = CH_X;
      6'd1, 6'd8, 6'd15:   w_char = CH_EQ;
      6'd2:                w_char = hex_ascii(w_act[15:12]);
      6'd3:                w_char = hex_ascii(w_act[11:8]);
      6'd4:                w_char = hex_ascii(w_act[7:4]);
      6'd5:                w_char = hex_ascii(w_act[3:0]);
      6'd6, 6'd13:         w_char = CH_COMMA;
      6'd7:                w_char = CH_Y;
      6'd9:                w_char = hex_ascii(w_act[31:28]);
      6'd10:               w_char = hex_ascii(w_act[27:24]);
      6'd11:               w_char = hex_ascii(w_act[23:20]);
      6'd12:               w_char = hex_ascii(w_act[19:16]);
      6'd14:               w_char = CH_Z;
      6'd16:               w_char = hex_ascii(w_act[47:44]);
      6'd17:               w_char = hex_ascii(w_act[43:40]);
      6'd18:               w_char = hex_ascii(w_act[39:36]);
      6'd19:               w_char = hex_ascii(w_act[35:32]);
`ifdef ACCEL_FRAME_CSUM_EN
      6'd20:               w_char = CH_STAR;
      6'd21:               w_char = hex_ascii(r_csum[7:4]);
      6'd22:               w_char = hex_ascii(r_csum[3:0]);
`endif
      default:             w_char = ((CRLF != 0) && (r_k == 6'(TERM_K))) ? CH_CR : CH_LF;
    endcase
  end

  // Line sequencer: one pulse per char, each pulse waits for busy to rise then fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_frames   <= '0;
      r_gap_cnt  <= '0;
`ifdef ACCEL_FRAME_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: if (w_pend_full) begin
          r_k     <= '0;
`ifdef ACCEL_FRAME_CSUM_EN
          r_csum  <= '0;
`endif
          r_state <= EMIT;
        end
        EMIT: if (!tx_busy) begin
          r_tx_start <= 1'b1;
          r_tx_data  <= w_char;
`ifdef ACCEL_FRAME_CSUM_EN
          if (r_k < 6'd20) r_csum <= r_csum ^ w_char;
`endif
          r_state    <= ACK;
        end
        ACK: if (tx_busy) r_state <= DRAIN;
        DRAIN: if (!tx_busy) begin
          if (r_k == LAST_K) begin
            r_frames  <= r_frames + 16'd1;
            r_gap_cnt <= '0;
            r_state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            r_k     <= r_k + 6'd1;
            r_state <= EMIT;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) r_state   <= IDLE;
          else                       r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign frames_sent  = r_frames;
  assign frame_active = (r_state == EMIT) || (r_state == ACK) || (r_state == DRAIN);

endmodule
